// File: rtl/nclic_arbiter.sv
// rtl/nclic_arbiter.sv - N-CLIC interrupt scheduler: pending latch, arbitration, entry handshake, threshold stack
module nclic_arbiter #(
   parameter  int VecSize    = 8,
   parameter  int PrioLevels = 8,
   parameter  int StackDepth = 8,
   localparam int PrioWidth  = (PrioLevels > 1) ? $clog2(PrioLevels) : 1,
   localparam int VecWidth   = (VecSize > 1) ? $clog2(VecSize) : 1,
   localparam int DepthW     = $clog2(StackDepth + 1)
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [VecSize-1:0]             irq_i,
   input  logic [VecSize-1:0]             sw_pend_i,
   input  logic [VecSize-1:0]             vec_en_i,
   input  logic [VecSize*PrioWidth-1:0]   vec_prio_i,
   input  logic                           mie_i,
   input  logic                           thresh_we_i,
   input  logic [PrioWidth-1:0]           thresh_wdata_i,
   output logic                           take_req_o,
   output logic [VecWidth-1:0]            take_vec_o,
   output logic [PrioWidth-1:0]           take_prio_o,
   input  logic                           take_ack_i,
   input  logic                           ret_i,
   output logic [VecSize-1:0]             pend_o,
   output logic [PrioWidth-1:0]           thresh_o,
   output logic [DepthW-1:0]              depth_o,
   output logic                           err_o
);

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic                  load_req;

   logic [VecSize-1:0]    irq_q;
   logic [VecSize-1:0]    pend;
   logic [VecSize-1:0]    set_vec;
   logic [VecSize-1:0]    clr_vec;

   logic [PrioWidth-1:0]  thresh;
   logic [PrioWidth-1:0]  thresh_nxt;
   logic [PrioWidth-1:0]  stack [StackDepth];
   logic [PrioWidth-1:0]  stack_top;
   logic [DepthW-1:0]     depth;
   logic                  err;

   logic                  ack;
   logic                  pop;
   logic                  underflow;

   logic                  cand_found;
   logic [VecWidth-1:0]   cand_vec;
   logic [PrioWidth-1:0]  cand_prio;
   logic                  eligible;

   logic [VecWidth-1:0]   take_vec;
   logic [PrioWidth-1:0]  take_prio;

   // An ack only counts while a request is actually outstanding.
   assign ack       = (state == REQ) && take_ack_i;
   assign pop       = ret_i && (depth != '0);
   assign underflow = ret_i && (depth == '0);

   // Rising irq edges and software strobes set pending; the acked vector clears.
   always_comb begin
      set_vec = (irq_i & ~irq_q) | sw_pend_i;
      clr_vec = '0;
      if (ack) begin
         clr_vec[take_vec] = 1'b1;
      end
   end

   // Pending bits and irq edge history; set wins over a same-cycle clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_q <= '0;
         pend  <= '0;
      end else begin
         irq_q <= irq_i;
         pend  <= (pend & ~clr_vec) | set_vec;
      end
   end

   // Highest-priority enabled pending vector; strict compare keeps the lowest index on ties.
   always_comb begin
      cand_found = 1'b0;
      cand_vec   = '0;
      cand_prio  = '0;
      for (int k = 0; k < VecSize; k++) begin
         if (pend[k] && vec_en_i[k] &&
             (!cand_found || (vec_prio_i[k*PrioWidth +: PrioWidth] > cand_prio))) begin
            cand_found = 1'b1;
            cand_vec   = VecWidth'(k);
            cand_prio  = vec_prio_i[k*PrioWidth +: PrioWidth];
         end
      end
   end

   // Priority 0 can never exceed the threshold, so it is never taken.
   assign eligible = cand_found && (cand_prio > thresh) && mie_i &&
                     (depth < DepthW'(StackDepth));

   // Request FSM next state: latch a winner in IDLE, hold it in REQ until ack.
   always_comb begin
      state_nxt = state;
      load_req  = 1'b0;
      case (state)
         IDLE: begin
            if (eligible) begin
               state_nxt = REQ;
               load_req  = 1'b1;
            end
         end
         REQ: begin
            if (take_ack_i) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state and the frozen request payload.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         take_vec  <= '0;
         take_prio <= '0;
      end else begin
         state <= state_nxt;
         if (load_req) begin
            take_vec  <= cand_vec;
            take_prio <= cand_prio;
         end
      end
   end

   // Read the top of the threshold stack (slot depth-1).
   always_comb begin
      stack_top = '0;
      for (int k = 0; k < StackDepth; k++) begin
         if (depth == DepthW'(k + 1)) begin
            stack_top = stack[k];
         end
      end
   end

   // Threshold source: ack beats return beats CSR write; a return at depth 0 also blocks the write.
   always_comb begin
      thresh_nxt = thresh;
      if (ack) begin
         thresh_nxt = take_prio;
      end else if (pop) begin
         thresh_nxt = stack_top;
      end else if (thresh_we_i && !ret_i) begin
         thresh_nxt = thresh_wdata_i;
      end
   end

   // Threshold, nesting depth, stack slots and sticky underflow flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         thresh <= '0;
         depth  <= '0;
         err    <= 1'b0;
         for (int k = 0; k < StackDepth; k++) begin
            stack[k] <= '0;
         end
      end else begin
         thresh <= thresh_nxt;
         if (underflow) begin
            err <= 1'b1;
         end
         // Tail-chain pops then re-pushes the same value, so the stack is left as is.
         if (ack && !pop) begin
            depth <= depth + DepthW'(1);
            for (int k = 0; k < StackDepth; k++) begin
               if (depth == DepthW'(k)) begin
                  stack[k] <= thresh;
               end
            end
         end else if (pop && !ack) begin
            depth <= depth - DepthW'(1);
         end
      end
   end

   assign take_req_o  = (state == REQ);
   assign take_vec_o  = take_vec;
   assign take_prio_o = take_prio;
   assign pend_o      = pend;
   assign thresh_o    = thresh;
   assign depth_o     = depth;
   assign err_o       = err;

endmodule

// File: tb/tb_nclic_arbiter.sv
// tb/tb_nclic_arbiter.sv - scoreboard bench for nclic_arbiter against a queue-based reference model
module tb_nclic_arbiter;

   localparam int VS = 8;
   localparam int PW = 3;
   localparam int VW = 3;
   localparam int DW = 4;
   localparam int SD = 8;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [VS-1:0]   irq_i = '0;
   logic [VS-1:0]   sw_pend_i = '0;
   logic [VS-1:0]   vec_en_i = '0;
   logic [VS*PW-1:0] vec_prio_i = '0;
   logic            mie_i = 1'b0;
   logic            thresh_we_i = 1'b0;
   logic [PW-1:0]   thresh_wdata_i = '0;
   logic            take_req_o;
   logic [VW-1:0]   take_vec_o;
   logic [PW-1:0]   take_prio_o;
   logic            take_ack_i = 1'b0;
   logic            ret_i = 1'b0;
   logic [VS-1:0]   pend_o;
   logic [PW-1:0]   thresh_o;
   logic [DW-1:0]   depth_o;
   logic            err_o;

   int n_checks = 0;
   int n_errors = 0;

   nclic_arbiter dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .irq_i          (irq_i),
      .sw_pend_i      (sw_pend_i),
      .vec_en_i       (vec_en_i),
      .vec_prio_i     (vec_prio_i),
      .mie_i          (mie_i),
      .thresh_we_i    (thresh_we_i),
      .thresh_wdata_i (thresh_wdata_i),
      .take_req_o     (take_req_o),
      .take_vec_o     (take_vec_o),
      .take_prio_o    (take_prio_o),
      .take_ack_i     (take_ack_i),
      .ret_i          (ret_i),
      .pend_o         (pend_o),
      .thresh_o       (thresh_o),
      .depth_o        (depth_o),
      .err_o          (err_o)
   );

   always #5 clk = ~clk;

   // Reference model state
   bit [VS-1:0] m_pend = '0;
   bit [VS-1:0] m_irq_prev = '0;
   int          m_thresh = 0;
   int          m_stack[$];
   bit          m_err = 0;
   bit          m_req = 0;
   int          m_vec = 0;
   int          m_prio = 0;
   int          exp_vec[$];
   int          exp_prio[$];
   bit          req_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int prio_of(input int k);
      return int'(vec_prio_i[k*PW +: PW]);
   endfunction

   // Model: one clock of the scheduler rules, evaluated on the pre-edge state.
   task automatic model_step();
      int  best_v;
      int  best_p;
      bit  ack;
      bit  elig;
      ack    = m_req && take_ack_i;
      best_v = -1;
      best_p = 0;
      for (int p = 7; p >= 1; p--) begin
         for (int k = 0; k < VS; k++) begin
            if (best_v < 0 && m_pend[k] && vec_en_i[k] && prio_of(k) == p) begin
               best_v = k;
               best_p = p;
            end
         end
      end
      elig = (best_v >= 0) && (best_p > m_thresh) && mie_i && (m_stack.size() < SD);
      for (int k = 0; k < VS; k++) begin
         if ((irq_i[k] && !m_irq_prev[k]) || sw_pend_i[k]) m_pend[k] = 1'b1;
         else if (ack && k == m_vec) m_pend[k] = 1'b0;
      end
      m_irq_prev = irq_i;
      if (ret_i) begin
         if (m_stack.size() > 0) m_thresh = m_stack.pop_back();
         else m_err = 1'b1;
      end
      if (ack) begin
         m_stack.push_back(m_thresh);
         m_thresh = m_prio;
      end else if (!ret_i && thresh_we_i) begin
         m_thresh = int'(thresh_wdata_i);
      end
      if (m_req) begin
         if (ack) m_req = 1'b0;
      end else if (elig) begin
         m_req  = 1'b1;
         m_vec  = best_v;
         m_prio = best_p;
         exp_vec.push_back(best_v);
         exp_prio.push_back(best_p);
      end
   endtask

   // Advance the reference model on every clock; reset it with the DUT.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_pend = '0; m_irq_prev = '0; m_thresh = 0; m_stack.delete();
         m_err = 0; m_req = 0; m_vec = 0; m_prio = 0;
         exp_vec.delete(); exp_prio.delete();
      end else begin
         model_step();
      end
   end

   // Monitor: compare visible state each cycle and pop the scoreboard on each new request.
   always @(negedge clk) begin
      if (!reset_n) begin
         req_seen = 0;
      end else begin
         check("pend", 32'(pend_o), 32'(m_pend));
         check("thresh", 32'(thresh_o), 32'(m_thresh));
         check("depth", 32'(depth_o), 32'(m_stack.size()));
         check("err", 32'(err_o), 32'(m_err));
         check("take_req", 32'(take_req_o), 32'(m_req));
         if (take_req_o && !req_seen) begin
            if (exp_vec.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL req_unexpected: got vec %0d prio %0d, required no request", take_vec_o, take_prio_o);
            end else begin
               check("req_vec", 32'(take_vec_o), 32'(exp_vec.pop_front()));
               check("req_prio", 32'(take_prio_o), 32'(exp_prio.pop_front()));
            end
         end
         if (take_req_o && m_req) begin
            check("hold_vec", 32'(take_vec_o), 32'(m_vec));
            check("hold_prio", 32'(take_prio_o), 32'(m_prio));
         end
         req_seen = take_req_o;
      end
   end

   task automatic tick();
      @(negedge clk);
      sw_pend_i   = '0;
      thresh_we_i = 1'b0;
      ret_i       = 1'b0;
      take_ack_i  = 1'b0;
   endtask

   task automatic set_prio(input int v, input int p);
      vec_prio_i[v*PW +: PW] = PW'(p);
   endtask

   task automatic wait_req(input string name);
      int n;
      n = 0;
      while (!take_req_o && n < 30) begin
         tick();
         n++;
      end
      check(name, 32'(take_req_o), 32'd1);
   endtask

   task automatic do_ack();
      take_ack_i = 1'b1;
      tick();
   endtask

   task automatic do_ret();
      ret_i = 1'b1;
      tick();
   endtask

   task automatic enter(input int v, input int p);
      set_prio(v, p);
      sw_pend_i[v] = 1'b1;
      tick();
      wait_req("enter_req");
      do_ack();
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_req", 32'(take_req_o), 0);
      check("rst_vec", 32'(take_vec_o), 0);
      check("rst_prio", 32'(take_prio_o), 0);
      check("rst_pend", 32'(pend_o), 0);
      check("rst_thresh", 32'(thresh_o), 0);
      check("rst_depth", 32'(depth_o), 0);
      check("rst_err", 32'(err_o), 0);
      reset_n  = 1'b1;
      vec_en_i = '1;
      mie_i    = 1'b1;

      // irq latency and first entry
      set_prio(3, 5);
      irq_i[3] = 1'b1;
      tick();
      check("a_pend3", 32'(pend_o[3]), 1);
      check("a_req_early", 32'(take_req_o), 0);
      tick();
      check("a_req", 32'(take_req_o), 1);
      check("a_vec", 32'(take_vec_o), 3);
      check("a_prio", 32'(take_prio_o), 5);
      do_ack();
      check("a_thresh", 32'(thresh_o), 5);
      check("a_depth", 32'(depth_o), 1);
      check("a_pend_clr", 32'(pend_o[3]), 0);
      check("a_req_drop", 32'(take_req_o), 0);
      irq_i[3] = 1'b0;
      do_ret();

      // Equal priority tie goes to the lower index
      set_prio(1, 4);
      set_prio(6, 4);
      sw_pend_i = 8'h42;
      tick();
      wait_req("b_req1");
      check("b_vec1", 32'(take_vec_o), 1);
      do_ack();
      do_ret();
      wait_req("b_req6");
      check("b_vec6", 32'(take_vec_o), 6);
      do_ack();
      do_ret();

      // Threshold masking and nested entry
      thresh_we_i = 1'b1;
      thresh_wdata_i = 3'd5;
      tick();
      set_prio(2, 5);
      sw_pend_i[2] = 1'b1;
      repeat (6) tick();
      check("c_masked", 32'(take_req_o), 0);
      set_prio(4, 6);
      sw_pend_i[4] = 1'b1;
      tick();
      wait_req("c_req4");
      check("c_vec4", 32'(take_vec_o), 4);
      do_ack();
      check("c_thresh6", 32'(thresh_o), 6);
      do_ret();
      check("c_thresh5", 32'(thresh_o), 5);
      thresh_we_i = 1'b1;
      thresh_wdata_i = 3'd0;
      tick();
      wait_req("c_req2");
      do_ack();
      do_ret();

      // Request held stable through changes until ack
      set_prio(5, 3);
      sw_pend_i[5] = 1'b1;
      tick();
      wait_req("d_req5");
      for (int i = 0; i < 10; i++) begin
         if (i == 2) begin
            irq_i[7] = 1'b1;
            set_prio(7, 7);
            vec_en_i[5] = 1'b0;
         end
         tick();
      end
      check("d_vec_held", 32'(take_vec_o), 5);
      check("d_prio_held", 32'(take_prio_o), 3);
      do_ack();
      vec_en_i[5] = 1'b1;
      do_ret();
      wait_req("d_req7");
      check("d_vec7", 32'(take_vec_o), 7);
      do_ack();
      irq_i[7] = 1'b0;
      do_ret();

      // Underflow, tail-chain and stack full
      do_ret();
      check("e_err", 32'(err_o), 1);
      check("e_depth0", 32'(depth_o), 0);
      enter(0, 1);
      enter(1, 2);
      set_prio(2, 3);
      sw_pend_i[2] = 1'b1;
      tick();
      wait_req("e_req_tail");
      take_ack_i = 1'b1;
      ret_i = 1'b1;
      tick();
      check("e_tail_depth", 32'(depth_o), 2);
      check("e_tail_thresh", 32'(thresh_o), 3);
      do_ret();
      do_ret();
      for (int i = 0; i < SD; i++) begin
         thresh_we_i = 1'b1;
         thresh_wdata_i = 3'd0;
         tick();
         enter(0, 1);
      end
      thresh_we_i = 1'b1;
      thresh_wdata_i = 3'd0;
      sw_pend_i[0] = 1'b1;
      repeat (10) tick();
      check("e_full_depth", 32'(depth_o), SD);
      check("e_full_noreq", 32'(take_req_o), 0);

      // Asynchronous reset mid-handshake at depth 3
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         thresh_we_i = 1'b1;
         thresh_wdata_i = 3'd0;
         tick();
         enter(0, 1);
      end
      thresh_we_i = 1'b1;
      thresh_wdata_i = 3'd0;
      tick();
      sw_pend_i[0] = 1'b1;
      tick();
      wait_req("f_req");
      check("f_depth3", 32'(depth_o), 3);
      #2 reset_n = 1'b0;
      #1;
      check("f_req0", 32'(take_req_o), 0);
      check("f_vec0", 32'(take_vec_o), 0);
      check("f_prio0", 32'(take_prio_o), 0);
      check("f_pend0", 32'(pend_o), 0);
      check("f_thresh0", 32'(thresh_o), 0);
      check("f_depth0", 32'(depth_o), 0);
      check("f_err0", 32'(err_o), 0);
      tick();
      reset_n = 1'b1;

      // Randomized traffic against the model
      for (int k = 0; k < VS; k++) set_prio(k, int'($urandom_range(0, 7)));
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 9) == 0) irq_i[$urandom_range(0, VS-1)] ^= 1'b1;
         if ($urandom_range(0, 7) == 0) sw_pend_i[$urandom_range(0, VS-1)] = 1'b1;
         if ($urandom_range(0, 39) == 0) vec_en_i[$urandom_range(0, VS-1)] ^= 1'b1;
         if ($urandom_range(0, 29) == 0) set_prio(int'($urandom_range(0, VS-1)), int'($urandom_range(0, 7)));
         mie_i = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 24) == 0) begin
            thresh_we_i = 1'b1;
            thresh_wdata_i = PW'($urandom_range(0, 7));
         end
         ret_i = ($urandom_range(0, 11) == 0);
         take_ack_i = m_req && ($urandom_range(0, 2) == 0);
         @(negedge clk);
         sw_pend_i   = '0;
         thresh_we_i = 1'b0;
         ret_i       = 1'b0;
         take_ack_i  = 1'b0;
      end
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
